// File: rtl/dcb_pkg.sv
// dcb_pkg: shared constants and elaboration-time helpers for the data
// connection block. Holds the clog2 helper, the derived field widths,
// the configuration field offsets and the output-select encoding.
package dcb_pkg;

    // Output-select encoding: 0 passes the north track group straight
    // through; values from OSEL_WORD_BASE upward pick MAC output words.
    localparam int OSEL_PASS      = 0;
    localparam int OSEL_WORD_BASE = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int in_sel_w(input int groups);
        return (clog2(groups) > 1) ? clog2(groups) : 1;
    endfunction

    function automatic int out_sel_w(input int dataout);
        return clog2(dataout + 1);
    endfunction

    // Per-input field is {reg, en, sel}.
    function automatic int in_field_w(input int isw);
        return isw + 2;
    endfunction

    function automatic int conf_width(input int datain, input int groups,
                                      input int isw, input int osw);
        return datain * in_field_w(isw) + groups * osw;
    endfunction

    function automatic int chain_len(input int cw, input int cfg_bits);
        return (cw + cfg_bits - 1) / cfg_bits;
    endfunction

    function automatic int in_field_off(input int i, input int isw);
        return i * in_field_w(isw);
    endfunction

    // Output selects are packed directly above the last input field.
    function automatic int osel_off(input int g, input int datain,
                                    input int isw, input int osw);
        return datain * in_field_w(isw) + g * osw;
    endfunction

endpackage

// File: rtl/dcb_cfg_chain.sv
// dcb_cfg_chain: serial, double-buffered configuration store.
// A CHAIN_LEN*CFG_BITS shadow shift register is loaded one chunk per
// cfg_shift (entry at the MSB, exit at the LSB for daisy-chaining). A
// commit copies the shadow into the active configuration only when a
// full chain has been shifted since the last commit or reset; otherwise
// the commit is rejected and cfg_err pulses for one cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_shift, cfg_in  shift enable and incoming chunk
//   cfg_commit         request shadow -> active copy
//   cfg_out            shadow LSB chunk (registered)
//   cfg_full           CHAIN_LEN chunks shifted since commit/reset
//   cfg_err            one-cycle pulse after a rejected commit
//   active_cfg         active configuration vector
module dcb_cfg_chain
    import dcb_pkg::*;
#(
    parameter int CFG_BITS   = 8,
    parameter int CONF_WIDTH = 30,
    parameter int CHAIN_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_shift,
    input  logic [CFG_BITS-1:0]   cfg_in,
    input  logic                  cfg_commit,
    output logic [CFG_BITS-1:0]   cfg_out,
    output logic                  cfg_full,
    output logic                  cfg_err,
    output logic [CONF_WIDTH-1:0] active_cfg
);

    localparam int SH_W  = CHAIN_LEN * CFG_BITS;
    localparam int CNT_W = clog2(CHAIN_LEN + 1);

    logic [SH_W-1:0]  shadow;
    logic [CNT_W-1:0] cnt;
    logic             commit_ok;

    assign cfg_full  = (cnt == CNT_W'(CHAIN_LEN));
    assign commit_ok = cfg_commit & cfg_full;
    assign cfg_out   = shadow[CFG_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            cnt        <= '0;
            cfg_err    <= 1'b0;
            active_cfg <= '0;
        end else begin
            if (cfg_shift)
                shadow <= (shadow >> CFG_BITS) | (SH_W'(cfg_in) << (SH_W - CFG_BITS));

            // Active takes the pre-shift shadow; a shift in the commit
            // cycle becomes the first chunk of the next load.
            if (commit_ok) begin
                active_cfg <= shadow[CONF_WIDTH-1:0];
                cnt        <= cfg_shift ? CNT_W'(1) : '0;
            end else if (cfg_shift && !cfg_full) begin
                cnt <= cnt + CNT_W'(1);
            end

            cfg_err <= cfg_commit & ~cfg_full;
        end
    end

endmodule

// File: rtl/data_connection_block_mux.sv
// data_connection_block_mux: statically configured routing between W
// fabric tracks and a MAC's input/output words.
//   - Each of DATAIN MAC input words selects one WW-wide track group of
//     north_in, can be gated off, and optionally passes through a
//     one-cycle pipeline register.
//   - Each of the G track groups of south_out either passes north_in
//     through, carries one MAC output word, or drives zero.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cfg_shift, cfg_in, cfg_commit      serial configuration load/commit
//   cfg_out, cfg_full, cfg_err         chain output and status
//   north_in / south_out               fabric tracks in / out (W bits)
//   data_input                         words to the MAC (WW*DATAIN)
//   data_output                        words from the MAC (WW*DATAOUT)
module data_connection_block_mux
    import dcb_pkg::*;
#(
    parameter int W        = 16,
    parameter int WW       = 8,
    parameter int DATAIN   = 8,
    parameter int DATAOUT  = 4,
    parameter int CFG_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_shift,
    input  logic [CFG_BITS-1:0]     cfg_in,
    input  logic                    cfg_commit,
    output logic [CFG_BITS-1:0]     cfg_out,
    output logic                    cfg_full,
    output logic                    cfg_err,
    input  logic [W-1:0]            north_in,
    output logic [W-1:0]            south_out,
    output logic [WW*DATAIN-1:0]    data_input,
    input  logic [WW*DATAOUT-1:0]   data_output
);

    localparam int G          = W / WW;
    localparam int IN_SEL_W   = in_sel_w(G);
    localparam int OUT_SEL_W  = out_sel_w(DATAOUT);
    localparam int CONF_WIDTH = conf_width(DATAIN, G, IN_SEL_W, OUT_SEL_W);
    localparam int CHAIN_LEN  = chain_len(CONF_WIDTH, CFG_BITS);

    logic [CONF_WIDTH-1:0] active_cfg;

    dcb_cfg_chain #(
        .CFG_BITS  (CFG_BITS),
        .CONF_WIDTH(CONF_WIDTH),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_shift (cfg_shift),
        .cfg_in    (cfg_in),
        .cfg_commit(cfg_commit),
        .cfg_out   (cfg_out),
        .cfg_full  (cfg_full),
        .cfg_err   (cfg_err),
        .active_cfg(active_cfg)
    );

    for (genvar i = 0; i < DATAIN; i++) begin : g_in
        localparam int OFF = in_field_off(i, IN_SEL_W);

        logic [IN_SEL_W-1:0] sel;
        logic                en;
        logic                use_reg;
        logic [WW-1:0]       src;
        logic [WW-1:0]       gated_p0;
        logic [WW-1:0]       word_p1;

        assign sel     = active_cfg[OFF +: IN_SEL_W];
        assign en      = active_cfg[OFF + IN_SEL_W];
        assign use_reg = active_cfg[OFF + IN_SEL_W + 1];

        // Explicit compare mux: a select beyond the last group matches
        // nothing and yields zero instead of an out-of-range slice.
        always_comb begin
            src = '0;
            for (int g = 0; g < G; g++)
                if (sel == IN_SEL_W'(g)) src = north_in[g*WW +: WW];
        end

        assign gated_p0 = en ? src : '0;

        // p0 -> p1: loads every cycle so switching use_reg on a commit
        // sees an up-to-date value immediately.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) word_p1 <= '0;
            else        word_p1 <= gated_p0;
        end

        assign data_input[i*WW +: WW] = use_reg ? word_p1 : gated_p0;
    end

    for (genvar g = 0; g < G; g++) begin : g_grp
        localparam int OFF = osel_off(g, DATAIN, IN_SEL_W, OUT_SEL_W);

        logic [OUT_SEL_W-1:0] osel;
        logic [WW-1:0]        grp_out;

        assign osel = active_cfg[OFF +: OUT_SEL_W];

        always_comb begin
            grp_out = '0;
            if (osel == OUT_SEL_W'(OSEL_PASS)) begin
                grp_out = north_in[g*WW +: WW];
            end else begin
                for (int k = 0; k < DATAOUT; k++)
                    if (osel == OUT_SEL_W'(OSEL_WORD_BASE + k))
                        grp_out = data_output[k*WW +: WW];
            end
        end

        assign south_out[g*WW +: WW] = grp_out;
    end

endmodule

// File: tb/tb_data_connection_block_mux.sv
module tb_data_connection_block_mux;

    localparam int CL = 4;   // chunks per chain at default parameters

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_shift, cfg_commit;
    logic [7:0]  cfg_in;
    logic [15:0] north_in;
    logic [31:0] data_output;

    logic [7:0]  cfg_out0, cfg_out1;
    logic        cfg_full0, cfg_full1, cfg_err0, cfg_err1;
    logic [15:0] south0, south1;
    logic [63:0] din0, din1;

    int total = 0;
    int bad   = 0;

    // Reference state for the two daisy-chained instances.
    logic [7:0]  ch   [2][CL];   // shadow chunks, index 0 = LSB chunk
    logic [29:0] act  [2];
    logic [7:0]  pipe [2][8];
    int          cnt  [2];
    logic        errm [2];

    always #5 clk = ~clk;

    data_connection_block_mux u_dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_in(cfg_in),
        .cfg_commit(cfg_commit), .cfg_out(cfg_out0), .cfg_full(cfg_full0),
        .cfg_err(cfg_err0), .north_in(north_in), .south_out(south0),
        .data_input(din0), .data_output(data_output)
    );

    data_connection_block_mux u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_in(cfg_out0),
        .cfg_commit(cfg_commit), .cfg_out(cfg_out1), .cfg_full(cfg_full1),
        .cfg_err(cfg_err1), .north_in(north_in), .south_out(south1),
        .data_input(din1), .data_output(data_output)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Field access following the LSB-first layout: input i at 3*i is
    // {reg, en, sel}; group g output select at 24 + 3*g.
    function automatic logic [7:0] gated(int n, int i);
        int s;
        logic [7:0] src;
        s   = int'(act[n][i*3]);
        src = (s < 2) ? north_in[s*8 +: 8] : 8'h00;
        return act[n][i*3+1] ? src : 8'h00;
    endfunction

    function automatic logic [63:0] exp_din(int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i*8 +: 8] = act[n][i*3+2] ? pipe[n][i] : gated(n, i);
        return r;
    endfunction

    function automatic logic [15:0] exp_south(int n);
        logic [15:0] r;
        int o;
        r = '0;
        for (int g = 0; g < 2; g++) begin
            o = int'(act[n][24 + g*3 +: 3]);
            if (o == 0)      r[g*8 +: 8] = north_in[g*8 +: 8];
            else if (o <= 4) r[g*8 +: 8] = data_output[(o-1)*8 +: 8];
            else             r[g*8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [29:0] shadow_vec(int n);
        logic [31:0] v;
        for (int k = 0; k < CL; k++) v[k*8 +: 8] = ch[n][k];
        return v[29:0];
    endfunction

    task automatic reset_model();
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < CL; k++) ch[n][k] = 8'h00;
            for (int i = 0; i < 8; i++) pipe[n][i] = 8'h00;
            act[n]  = '0;
            cnt[n]  = 0;
            errm[n] = 1'b0;
        end
    endtask

    // Advance the reference by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        logic [7:0] feed;
        logic       full;
        feed = ch[0][0];
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 8; i++) pipe[n][i] = gated(n, i);
            full    = (cnt[n] == CL);
            errm[n] = cfg_commit && !full;
            if (cfg_commit && full) begin
                act[n] = shadow_vec(n);
                cnt[n] = cfg_shift ? 1 : 0;
            end else if (cfg_shift && cnt[n] < CL) begin
                cnt[n]++;
            end
            if (cfg_shift) begin
                for (int k = 0; k < CL-1; k++) ch[n][k] = ch[n][k+1];
                ch[n][CL-1] = (n == 0) ? cfg_in : feed;
            end
        end
    endtask

    task automatic check_all();
        chk("din0",   din0,      exp_din(0));
        chk("south0", south0,    exp_south(0));
        chk("full0",  cfg_full0, cnt[0] == CL);
        chk("cout0",  cfg_out0,  ch[0][0]);
        chk("err0",   cfg_err0,  errm[0]);
        chk("din1",   din1,      exp_din(1));
        chk("south1", south1,    exp_south(1));
        chk("full1",  cfg_full1, cnt[1] == CL);
        chk("cout1",  cfg_out1,  ch[1][0]);
        chk("err1",   cfg_err1,  errm[1]);
    endtask

    task automatic step(input bit sh, input bit cm, input logic [7:0] d);
        cfg_shift  = sh;
        cfg_commit = cm;
        cfg_in     = d;
        @(posedge clk);
        model_edge();
        #1;
        cfg_shift  = 1'b0;
        cfg_commit = 1'b0;
        check_all();
    endtask

    task automatic load(input logic [29:0] v);
        logic [31:0] w;
        w = {2'b00, v};
        for (int k = 0; k < CL; k++) step(1'b1, 1'b0, w[k*8 +: 8]);
    endtask

    initial begin
        logic [29:0] cfg_a, cfg_b, cfg_c, cfg_d0, cfg_d1;
        logic [31:0] wd;

        rst_n = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0; cfg_in = 8'h00;
        north_in = 16'hA55A; data_output = 32'hC3B2A190;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_south", south0, 16'hA55A);
        chk("rst_din", din0, 64'h0);
        chk("rst_full", cfg_full0, 1'b0);
        chk("rst_cout", cfg_out0, 8'h00);
        rst_n = 1'b1;

        // input0 {reg0,en1,sel1}, input3 {reg1,en1,sel0}, group0 -> word 1
        cfg_a = '0;
        cfg_a[0 +: 3]  = 3'b011;
        cfg_a[9 +: 3]  = 3'b110;
        cfg_a[24 +: 3] = 3'd2;
        load(cfg_a);
        chk("full_after4", cfg_full0, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        chk("route_in0", din0[7:0], north_in[15:8]);
        chk("route_g0", south0[7:0], data_output[15:8]);
        chk("commit_err", cfg_err0, 1'b0);
        north_in = 16'h7E3C;
        #1;
        chk("route_in0_comb", din0[7:0], 8'h7E);

        north_in = 16'h0011;
        step(1'b0, 1'b0, 8'h00);
        chk("pipe_11", din0[31:24], 8'h11);
        north_in = 16'h0022;
        #1;
        chk("pipe_hold", din0[31:24], 8'h11);
        step(1'b0, 1'b0, 8'h00);
        chk("pipe_22", din0[31:24], 8'h22);

        // Commit after only three chunks is rejected.
        cfg_b = 30'($urandom);
        wd = {2'b00, cfg_b};
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, wd[k*8 +: 8]);
        step(1'b0, 1'b1, 8'h00);
        chk("err_pulse", cfg_err0, 1'b1);
        chk("err_full", cfg_full0, 1'b0);
        chk("err_keep", din0[7:0], north_in[15:8]);
        step(1'b0, 1'b0, 8'h00);
        chk("err_once", cfg_err0, 1'b0);
        step(1'b1, 1'b0, wd[31:24]);
        step(1'b0, 1'b1, 8'h00);
        chk("commit_ok_err", cfg_err0, 1'b0);

        // Commit with a simultaneous shift keeps the pre-shift shadow.
        cfg_c = 30'($urandom);
        load(cfg_c);
        step(1'b1, 1'b1, 8'h5D);
        chk("same_full", cfg_full0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'(k + 1));
        chk("same_cnt4", cfg_full0, 1'b1);

        // Randomized traffic and configuration.
        for (int c = 0; c < 400; c++) begin
            north_in    = 16'($urandom);
            data_output = $urandom;
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        // Daisy chain: first four chunks end up in instance 1.
        step(1'b0, 1'b0, 8'h00);
        cfg_d0 = 30'($urandom);
        cfg_d1 = 30'($urandom);
        wd = {2'b00, cfg_d1};
        for (int k = 0; k < CL; k++) step(1'b1, 1'b0, wd[k*8 +: 8]);
        wd = {2'b00, cfg_d0};
        for (int k = 0; k < CL; k++) step(1'b1, 1'b0, wd[k*8 +: 8]);
        step(1'b0, 1'b1, 8'h00);
        chk("daisy_act0", act[0], cfg_d0);
        chk("daisy_act1", act[1], cfg_d1);
        for (int c = 0; c < 4; c++) begin
            north_in    = 16'($urandom);
            data_output = $urandom;
            step(1'b0, 1'b0, 8'h00);
        end

        // Asynchronous reset in the middle of a chain load.
        step(1'b1, 1'b0, 8'hE7);
        step(1'b1, 1'b0, 8'h9A);
        north_in = 16'hBEEF;
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all();
        chk("arst_south1", south1, 16'hBEEF);
        chk("arst_din1", din1, 64'h0);
        chk("arst_cout0", cfg_out0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            north_in    = 16'($urandom);
            data_output = $urandom;
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
